// File: rtl/counter_time_unit_pkg.sv
// ============================================================================
//  Module      : counter_time_unit_pkg
//  Description : Shared time-of-day range constants and BCD helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_time_unit_pkg;

    localparam int SEC_MIN = 0;
    localparam int SEC_MAX = 59;
    localparam int MIN_MIN = 0;
    localparam int MIN_MAX = 59;
    localparam int H24_MIN = 0;
    localparam int H24_MAX = 23;
    localparam int H12_MIN = 1;
    localparam int H12_MAX = 12;
    localparam int BCD_W   = 8;

    // Elaboration-time conversion, used for reset constants only.
    function automatic logic [BCD_W-1:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_99.sv
// ============================================================================
//  Module      : bin2bcd_99
//  Description : Combinational binary (0..99) to packed BCD {tens, ones}.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_99
    import counter_time_unit_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] bin,
    output logic [BCD_W-1:0] bcd
);

    logic [3:0] w_tens;
    logic [3:0] w_ones;

    // Threshold ladder instead of a divider: the range is small and fixed.
    always_comb begin
        w_tens = 4'd0;
        for (int t = 1; t <= 9; t++) begin
            if (int'(bin) >= 10 * t) begin
                w_tens = 4'(t);
            end
        end
        w_ones = 4'(int'(bin) - 10 * int'(w_tens));
        bcd    = {w_tens, w_ones};
    end

endmodule

`default_nettype wire

// File: rtl/counter_time_unit.sv
// ============================================================================
//  Module      : counter_time_unit
//  Description : Cascadable up/down modulo counter for one time-of-day digit
//                pair with range-checked preset and registered BCD output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_time_unit
    import counter_time_unit_pkg::*;
#(
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 59,
    parameter int WIDTH   = 7
) (
    input  logic             clk,
    input  logic             CR,
    input  logic             en,
    input  logic             PE,
    input  logic             dir,
    input  logic [WIDTH-1:0] pre_val,
    output logic [WIDTH-1:0] show_val,
    output logic [BCD_W-1:0] show_bcd,
    output logic             cout,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] c_min     = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] c_max     = WIDTH'(MAX_VAL);
    localparam logic [BCD_W-1:0] c_min_bcd = to_bcd(MIN_VAL);

    logic [WIDTH-1:0] w_next_val;
    logic [BCD_W-1:0] w_next_bcd;
    logic             w_next_cout;
    logic             w_next_err;

    // Wrap is decided before the add, so MAX_VAL+1 / MIN_VAL-1 never exist.
    always_comb begin
        w_next_val  = show_val;
        w_next_cout = 1'b0;
        w_next_err  = 1'b0;
        if (PE) begin
            if (in_range(int'(pre_val), MIN_VAL, MAX_VAL)) begin
                w_next_val = pre_val;
            end else begin
                w_next_err = 1'b1;
            end
        end else if (en) begin
            if (!dir) begin
                if (show_val == c_max) begin
                    w_next_val  = c_min;
                    w_next_cout = 1'b1;
                end else begin
                    w_next_val = show_val + WIDTH'(1);
                end
            end else begin
                if (show_val == c_min) begin
                    w_next_val  = c_max;
                    w_next_cout = 1'b1;
                end else begin
                    w_next_val = show_val - WIDTH'(1);
                end
            end
        end
    end

    bin2bcd_99 #(
        .WIDTH (WIDTH)
    ) u_bin2bcd (
        .bin (w_next_val),
        .bcd (w_next_bcd)
    );

    always_ff @(posedge clk) begin
        if (CR) begin
            show_val <= c_min;
            show_bcd <= c_min_bcd;
            cout     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            show_val <= w_next_val;
            show_bcd <= w_next_bcd;
            cout     <= w_next_cout;
            load_err <= w_next_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_counter_time_unit.sv
// ============================================================================
//  Module      : tb_counter_time_unit
//  Description : Scoreboard bench for counter_time_unit (several ranges and
//                a sec/min/hour cascade).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_time_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // group 0: 0..59, group 1: 1..12, group 2: 0..23, group 3: cascade
    logic       cr0, pe0, en0, dir0;
    logic [6:0] pre0;
    logic [6:0] val0;
    logic [7:0] bcd0;
    logic       cout0, err0;

    logic       cr1, pe1, en1, dir1;
    logic [3:0] pre1;
    logic [3:0] val1;
    logic [7:0] bcd1;
    logic       cout1, err1;

    logic       cr2, pe2, en2, dir2;
    logic [4:0] pre2;
    logic [4:0] val2;
    logic [7:0] bcd2;
    logic       cout2, err2;

    logic       cr3, pe3, en3;
    logic [5:0] pre_s, pre_m;
    logic [4:0] pre_h;
    logic [5:0] val_s, val_m;
    logic [4:0] val_h;
    logic [7:0] bcd_s, bcd_m, bcd_h;
    logic       cout_s, cout_m, cout_h, err_s, err_m, err_h;

    counter_time_unit #(.MIN_VAL(0), .MAX_VAL(59), .WIDTH(7)) u_d0 (
        .clk(clk), .CR(cr0), .en(en0), .PE(pe0), .dir(dir0), .pre_val(pre0),
        .show_val(val0), .show_bcd(bcd0), .cout(cout0), .load_err(err0));

    counter_time_unit #(.MIN_VAL(1), .MAX_VAL(12), .WIDTH(4)) u_d1 (
        .clk(clk), .CR(cr1), .en(en1), .PE(pe1), .dir(dir1), .pre_val(pre1),
        .show_val(val1), .show_bcd(bcd1), .cout(cout1), .load_err(err1));

    counter_time_unit #(.MIN_VAL(0), .MAX_VAL(23), .WIDTH(5)) u_d2 (
        .clk(clk), .CR(cr2), .en(en2), .PE(pe2), .dir(dir2), .pre_val(pre2),
        .show_val(val2), .show_bcd(bcd2), .cout(cout2), .load_err(err2));

    counter_time_unit #(.MIN_VAL(0), .MAX_VAL(59), .WIDTH(6)) u_sec (
        .clk(clk), .CR(cr3), .en(en3), .PE(pe3), .dir(1'b0), .pre_val(pre_s),
        .show_val(val_s), .show_bcd(bcd_s), .cout(cout_s), .load_err(err_s));

    counter_time_unit #(.MIN_VAL(0), .MAX_VAL(59), .WIDTH(6)) u_min (
        .clk(clk), .CR(cr3), .en(cout_s), .PE(pe3), .dir(1'b0), .pre_val(pre_m),
        .show_val(val_m), .show_bcd(bcd_m), .cout(cout_m), .load_err(err_m));

    counter_time_unit #(.MIN_VAL(0), .MAX_VAL(23), .WIDTH(5)) u_hour (
        .clk(clk), .CR(cr3), .en(cout_m), .PE(pe3), .dir(1'b0), .pre_val(pre_h),
        .show_val(val_h), .show_bcd(bcd_h), .cout(cout_h), .load_err(err_h));

    typedef struct {
        int    id;
        string name;
        int    val;
        int    bcd;
        int    cout;
        int    err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic int dec2bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic push(input int id, input string nm, input int v, input int c, input int e);
        exp_t x;
        x.id = id; x.name = nm; x.val = v; x.bcd = dec2bcd(v); x.cout = c; x.err = e;
        q.push_back(x);
    endtask

    task automatic clear_ctl();
        cr0 = 0; pe0 = 0; en0 = 0;
        cr1 = 0; pe1 = 0; en1 = 0;
        cr2 = 0; pe2 = 0; en2 = 0;
        cr3 = 0; pe3 = 0; en3 = 0;
    endtask

    task automatic apply(input int g, input bit cr, input bit pe, input bit e, input bit d,
                         input int pre, input int ev, input int ec, input int ee, input string nm);
        @(negedge clk);
        clear_ctl();
        case (g)
            0: begin cr0 = cr; pe0 = pe; en0 = e; dir0 = d; pre0 = 7'(pre); end
            1: begin cr1 = cr; pe1 = pe; en1 = e; dir1 = d; pre1 = 4'(pre); end
            default: begin cr2 = cr; pe2 = pe; en2 = e; dir2 = d; pre2 = 5'(pre); end
        endcase
        push(g, nm, ev, ec, ee);
    endtask

    task automatic apply3(input bit pe, input bit e, input int es, input int cs,
                          input int em, input int cm, input int eh, input int ch, input string nm);
        @(negedge clk);
        clear_ctl();
        pe3 = pe; en3 = e;
        push(3, {nm, ".sec"}, es, cs, 0);
        push(4, {nm, ".min"}, em, cm, 0);
        push(5, {nm, ".hour"}, eh, ch, 0);
    endtask

    // Monitor: every registered output is presented one edge after stimulus.
    always @(posedge clk) begin
        exp_t x;
        int av, ab, ac, ae;
        #1;
        while (q.size() > 0) begin
            x = q.pop_front();
            case (x.id)
                0: begin av = int'(val0);  ab = int'(bcd0);  ac = int'(cout0);  ae = int'(err0);  end
                1: begin av = int'(val1);  ab = int'(bcd1);  ac = int'(cout1);  ae = int'(err1);  end
                2: begin av = int'(val2);  ab = int'(bcd2);  ac = int'(cout2);  ae = int'(err2);  end
                3: begin av = int'(val_s); ab = int'(bcd_s); ac = int'(cout_s); ae = int'(err_s); end
                4: begin av = int'(val_m); ab = int'(bcd_m); ac = int'(cout_m); ae = int'(err_m); end
                default: begin av = int'(val_h); ab = int'(bcd_h); ac = int'(cout_h); ae = int'(err_h); end
            endcase
            chk({x.name, ".val"}, av, x.val);
            chk({x.name, ".bcd"}, ab, x.bcd);
            chk({x.name, ".cout"}, ac, x.cout);
            chk({x.name, ".err"}, ae, x.err);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_ctl();
        dir0 = 0; dir1 = 0; dir2 = 0;
        pre0 = 0; pre1 = 0; pre2 = 0;
        pre_s = 6'd58; pre_m = 6'd59; pre_h = 5'd23;

        // Reset all counters for two cycles.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cr0 = 1; cr1 = 1; cr2 = 1; cr3 = 1;
            push(0, "rst.d0", 0, 0, 0);
            push(1, "rst.d1", 1, 0, 0);
            push(2, "rst.d2", 0, 0, 0);
            push(3, "rst.sec", 0, 0, 0);
            push(4, "rst.min", 0, 0, 0);
            push(5, "rst.hour", 0, 0, 0);
        end

        // 60 consecutive up-counts: 1..59, then wrap to 0 with a single carry.
        for (int i = 1; i <= 60; i++) begin
            apply(0, 0, 0, 1, 0, 0, i % 60, (i == 60) ? 1 : 0, 0, $sformatf("walk%0d", i));
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, "walk_hold");

        // 1..12 range: wrap up and borrow down, then an under-range preset.
        apply(1, 0, 1, 0, 0, 12, 12, 0, 0, "h12_load12");
        apply(1, 0, 0, 1, 0, 0, 1, 1, 0, "h12_wrap_up");
        apply(1, 0, 0, 1, 1, 0, 12, 1, 0, "h12_wrap_dn");
        apply(1, 0, 0, 1, 1, 0, 11, 0, 0, "h12_dn");
        apply(1, 0, 1, 0, 0, 0, 11, 0, 1, "h12_load0_rej");
        apply(1, 0, 0, 0, 0, 0, 11, 0, 0, "h12_hold");

        // 0..23 range: over-range preset rejected, then max preset accepted.
        apply(2, 0, 1, 0, 0, 7, 7, 0, 0, "h24_load7");
        apply(2, 0, 1, 0, 0, 24, 7, 0, 1, "h24_load24_rej");
        apply(2, 0, 0, 0, 0, 0, 7, 0, 0, "h24_err_pulse");
        apply(2, 0, 1, 0, 0, 23, 23, 0, 0, "h24_load23");
        apply(2, 0, 0, 1, 0, 0, 0, 1, 0, "h24_wrap");

        // Load beats count at 59, then reset beats everything.
        apply(0, 0, 1, 0, 0, 59, 59, 0, 0, "ld59");
        apply(0, 0, 1, 1, 0, 30, 30, 0, 0, "ld_vs_en");
        apply(0, 0, 0, 1, 1, 0, 29, 0, 0, "dn29");
        apply(0, 0, 1, 0, 0, 45, 45, 0, 0, "ld45");
        apply(0, 1, 0, 1, 0, 0, 0, 0, 0, "cr_vs_en");
        apply(0, 0, 0, 1, 0, 0, 1, 0, 0, "after_cr");
        apply(0, 1, 1, 0, 0, 99, 0, 0, 0, "cr_vs_bad_pe");
        apply(0, 0, 0, 1, 1, 0, 59, 1, 0, "dn_wrap");

        // Cascade 23:59:58 with seconds enable held high.
        apply3(1, 0, 58, 0, 59, 0, 23, 0, "cas_load");
        apply3(0, 1, 59, 0, 59, 0, 23, 0, "cas_t1");
        apply3(0, 1, 0, 1, 59, 0, 23, 0, "cas_t2");
        apply3(0, 1, 1, 0, 0, 1, 23, 0, "cas_t3");
        apply3(0, 1, 2, 0, 0, 0, 0, 1, "cas_t4");
        apply3(0, 1, 3, 0, 0, 0, 0, 0, "cas_t5");

        @(negedge clk);
        clear_ctl();
        @(negedge clk);
        chk("queue_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
